dino_jump_ctrl: RTL and testbench

Parametrised successor to the first-generation jump/game-status block of the dinosaur game. It adds reset, button edge detection, a game FSM with a game-over state, and tick-paced ballistic jump physics (launch velocity, gravity, landing, ceiling clamp). It sits between the debounced button input, the obstacle/collision logic and the VGA renderer, which consumes dinosaur_height and game_status.

---
 rtl/dino_pkg.sv | 22 ++
 rtl/dino_jump_ctrl_if.sv | 23 ++
 rtl/dino_tick_gen.sv | 31 +++
 rtl/dino_jump_ctrl.sv | 150 +++++++++++++++
 tb/tb_dino_jump_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/dino_pkg.sv
// Shared types and default constants for the dinosaur jump/game-status block.
package dino_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GROUND = 2'd1,
        AIR    = 2'd2,
        OVER   = 2'd3
    } dino_state_e;

    localparam int DEF_HEIGHT_W   = 6;
    localparam int DEF_MAX_HEIGHT = 40;
    localparam int DEF_JUMP_VEL   = 7;
    localparam int DEF_GRAVITY    = 1;
    localparam int DEF_TICK_DIV   = 500000;

    // Two extra bits give a sign bit and headroom for height + velocity.
    function automatic int vel_width(input int height_w);
        return height_w + 2;
    endfunction

endpackage

// File: rtl/dino_jump_ctrl_if.sv
// Button/collision inputs and renderer-facing outputs of the jump controller.
interface dino_jump_ctrl_if
    import dino_pkg::*;
#(
    parameter int HEIGHT_W = DEF_HEIGHT_W
);
    logic                button_jump;
    logic                collision;
    logic [HEIGHT_W-1:0] dinosaur_height;
    logic                game_status;
    logic                game_over;
    logic                airborne;

    modport master (
        output button_jump, collision,
        input  dinosaur_height, game_status, game_over, airborne
    );

    modport slave (
        input  button_jump, collision,
        output dinosaur_height, game_status, game_over, airborne
    );
endinterface

// File: rtl/dino_tick_gen.sv
// Physics tick generator: one-cycle pulse every TICK_DIV enabled CLK cycles.
module dino_tick_gen
    import dino_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int              CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= (count_q == LAST) ? '0 : count_q + CNT_W'(1);
        end
    end

    assign tick = enable && (count_q == LAST);

endmodule

// File: rtl/dino_jump_ctrl.sv
// Game FSM and tick-paced ballistic jump physics for the dinosaur game.
// Optional double jump is compiled in with `define DINO_DOUBLE_JUMP_EN.
module dino_jump_ctrl
    import dino_pkg::*;
#(
    parameter int HEIGHT_W   = DEF_HEIGHT_W,
    parameter int MAX_HEIGHT = DEF_MAX_HEIGHT,
    parameter int JUMP_VEL   = DEF_JUMP_VEL,
    parameter int GRAVITY    = DEF_GRAVITY,
    parameter int TICK_DIV   = DEF_TICK_DIV
) (
    input logic             CLK,
    input logic             rst_n,
    dino_jump_ctrl_if.slave bus
);
    localparam int VEL_W = vel_width(HEIGHT_W);

    typedef logic signed [VEL_W-1:0] vel_t;

    localparam vel_t JUMP_V = vel_t'(JUMP_VEL);
    localparam vel_t GRAV_V = vel_t'(GRAVITY);
    localparam vel_t MAX_V  = vel_t'(MAX_HEIGHT);

    dino_state_e         state_q, state_d;
    logic [HEIGHT_W-1:0] height_q, height_d;
    vel_t                vel_q, vel_d;
    vel_t                next_h;
    logic                button_prev_q;
    logic                press;
    logic                tick;
    logic                game_status_q, game_over_q, airborne_q;
`ifdef DINO_DOUBLE_JUMP_EN
    logic                dj_used_q, dj_used_d;
`endif

    assign press  = bus.button_jump & ~button_prev_q;
    assign next_h = $signed({2'b00, height_q}) + vel_q;

    dino_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .CLK    (CLK),
        .rst_n  (rst_n),
        .enable ((state_q == GROUND) || (state_q == AIR)),
        .clear  ((state_q == IDLE) && press),
        .tick   (tick)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            height_q      <= '0;
            vel_q         <= '0;
            button_prev_q <= 1'b0;
            game_status_q <= 1'b0;
            game_over_q   <= 1'b0;
            airborne_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            height_q      <= height_d;
            vel_q         <= vel_d;
            button_prev_q <= bus.button_jump;
            game_status_q <= (state_q == GROUND) || (state_q == AIR);
            game_over_q   <= (state_q == OVER);
            airborne_q    <= (state_q == AIR);
        end
    end

`ifdef DINO_DOUBLE_JUMP_EN
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) dj_used_q <= 1'b0;
        else        dj_used_q <= dj_used_d;
    end
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        height_d = height_q;
        vel_d    = vel_q;
`ifdef DINO_DOUBLE_JUMP_EN
        dj_used_d = dj_used_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (press) begin
                    state_d  = GROUND;
                    height_d = '0;
                    vel_d    = '0;
                end
            end
            GROUND: begin
                height_d = '0;
                if (bus.collision) begin
                    state_d = OVER;
                end else if (press) begin
                    state_d = AIR;
                    vel_d   = JUMP_V;
`ifdef DINO_DOUBLE_JUMP_EN
                    dj_used_d = 1'b0;
`endif
                end
            end
            AIR: begin
                // Collision freezes height and velocity exactly where they are.
                if (bus.collision) begin
                    state_d = OVER;
                end else begin
                    if (tick) begin
                        if (next_h <= 0) begin
                            state_d  = GROUND;
                            height_d = '0;
                            vel_d    = '0;
`ifdef DINO_DOUBLE_JUMP_EN
                            dj_used_d = 1'b0;
`endif
                        end else if (next_h > MAX_V) begin
                            height_d = HEIGHT_W'(MAX_HEIGHT);
                            vel_d    = '0;
                        end else begin
                            height_d = next_h[HEIGHT_W-1:0];
                            vel_d    = vel_q - GRAV_V;
                        end
                    end
`ifdef DINO_DOUBLE_JUMP_EN
                    // A second launch overrides the tick's velocity update, unless this tick lands.
                    if (press && !dj_used_q && (state_d == AIR)) begin
                        vel_d     = JUMP_V;
                        dj_used_d = 1'b1;
                    end
`endif
                end
            end
            OVER: begin
                if (press) begin
                    state_d  = IDLE;
                    height_d = '0;
                    vel_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.dinosaur_height = height_q;
    assign bus.game_status     = game_status_q;
    assign bus.game_over       = game_over_q;
    assign bus.airborne        = airborne_q;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Directed bench for dino_jump_ctrl; main DUT uses MAX_HEIGHT=40, a second copy MAX_HEIGHT=4.
module tb_dino_jump_ctrl;
    import dino_pkg::*;

    localparam int TD = 4;

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    logic btn = 1'b0;
    logic col = 1'b0;

    always #5 CLK = ~CLK;

    dino_jump_ctrl_if #(.HEIGHT_W(6)) bus_a ();
    dino_jump_ctrl_if #(.HEIGHT_W(6)) bus_b ();

    assign bus_a.button_jump = btn;
    assign bus_a.collision   = col;
    assign bus_b.button_jump = btn;
    assign bus_b.collision   = col;

    dino_jump_ctrl #(
        .HEIGHT_W(6), .MAX_HEIGHT(40), .JUMP_VEL(3), .GRAVITY(1), .TICK_DIV(TD)
    ) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    dino_jump_ctrl #(
        .HEIGHT_W(6), .MAX_HEIGHT(4), .JUMP_VEL(3), .GRAVITY(1), .TICK_DIV(TD)
    ) dut_b (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int phase    = 0;   // enabled edges since game start, mod TD
    bit running  = 1'b0;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    task automatic cycle();
        @(posedge CLK);
        if (running) phase = (phase + 1) % TD;
        @(negedge CLK);
    endtask

    task automatic press(input bit start);
        btn = 1'b1;
        @(posedge CLK);
        if (start) begin
            running = 1'b1;
            phase   = 0;
        end else if (running) begin
            phase = (phase + 1) % TD;
        end
        @(negedge CLK);
        btn = 1'b0;
    endtask

    task automatic next_tick();
        int n = 0;
        do begin
            cycle();
            n++;
        end while (phase != 0 && n < 2 * TD);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_a[7] = '{3, 5, 6, 6, 5, 3, 0};
        int exp_b[7] = '{3, 4, 4, 3, 1, 0, 0};
`ifdef DINO_DOUBLE_JUMP_EN
        int exp_dj[3] = '{8, 10, 11};
`else
        int exp_dj[3] = '{6, 6, 5};
`endif

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_height",   int'(bus_a.dinosaur_height), 0);
        check("rst_status",   int'(bus_a.game_status), 0);
        check("rst_over",     int'(bus_a.game_over), 0);
        check("rst_airborne", int'(bus_a.airborne), 0);
        check("rst_state",    int'(dut.state_q), int'(IDLE));
        rst_n = 1'b1;
        cycle();

        // Test 1: start game, hold button 20 cycles without launching
        btn = 1'b1;
        @(posedge CLK);
        running = 1'b1;
        phase   = 0;
        @(negedge CLK);
        cycle();
        check("t1_status", int'(bus_a.game_status), 1);
        check("t1_height", int'(bus_a.dinosaur_height), 0);
        repeat (18) cycle();
        check("t1_hold_airborne", int'(bus_a.airborne), 0);
        check("t1_hold_state",    int'(dut.state_q), int'(GROUND));
        btn = 1'b0;
        cycle();

        // Tests 2/3: launch; trajectories with ceiling 40 and ceiling 4
        press(1'b0);
        for (int k = 0; k < 7; k++) begin
            next_tick();
            if (k == 0) check("t2_airborne", int'(bus_a.airborne), 1);
            check($sformatf("t2_height_tick%0d", k), int'(bus_a.dinosaur_height), exp_a[k]);
            check($sformatf("t3_height_tick%0d", k), int'(bus_b.dinosaur_height), exp_b[k]);
        end
        cycle();
        check("t2_landed_airborne", int'(bus_a.airborne), 0);
        check("t2_landed_state",    int'(dut.state_q), int'(GROUND));
        check("t2_landed_vel",      int'(dut.vel_q), 0);
        check("t2_landed_status",   int'(bus_a.game_status), 1);

        // Test 4: collision at height 5 freezes the game
        press(1'b0);
        next_tick();
        next_tick();
        check("t4_pre_height", int'(bus_a.dinosaur_height), 5);
        col = 1'b1;
        cycle();
        running = 1'b0;
        col = 1'b0;
        cycle();
        check("t4_over",     int'(bus_a.game_over), 1);
        check("t4_status",   int'(bus_a.game_status), 0);
        check("t4_airborne", int'(bus_a.airborne), 0);
        repeat (50) cycle();
        check("t4_frozen_height", int'(bus_a.dinosaur_height), 5);
        check("t4_frozen_over",   int'(bus_a.game_over), 1);
        press(1'b0);
        cycle();
        check("t4_idle_height", int'(bus_a.dinosaur_height), 0);
        check("t4_idle_over",   int'(bus_a.game_over), 0);
        check("t4_idle_state",  int'(dut.state_q), int'(IDLE));

        // Collision and press in the same GROUND cycle: collision wins
        press(1'b1);
        cycle();
        btn = 1'b1;
        col = 1'b1;
        cycle();
        running = 1'b0;
        btn = 1'b0;
        col = 1'b0;
        cycle();
        check("t4_tie_state",    int'(dut.state_q), int'(OVER));
        check("t4_tie_over",     int'(bus_a.game_over), 1);
        check("t4_tie_airborne", int'(bus_a.airborne), 0);
        press(1'b0);
        cycle();

        // Test 5: asynchronous reset mid-air at height 6
        press(1'b1);
        cycle();
        press(1'b0);
        repeat (3) next_tick();
        check("t5_pre_height", int'(bus_a.dinosaur_height), 6);
        #2 rst_n = 1'b0;
        #1;
        running = 1'b0;
        check("t5_rst_height",   int'(bus_a.dinosaur_height), 0);
        check("t5_rst_status",   int'(bus_a.game_status), 0);
        check("t5_rst_airborne", int'(bus_a.airborne), 0);
        check("t5_rst_state",    int'(dut.state_q), int'(IDLE));
        check("t5_rst_vel",      int'(dut.vel_q), 0);
        @(negedge CLK);
        rst_n = 1'b1;
        cycle();
        press(1'b1);
        cycle();
        check("t5_restart_status", int'(bus_a.game_status), 1);
        press(1'b0);
        next_tick();
        check("t5_restart_height", int'(bus_a.dinosaur_height), 3);

        // Test 6: press in AIR at height 5 (double jump only when enabled), then a third press
        next_tick();
        check("t6_pre_height", int'(bus_a.dinosaur_height), 5);
        press(1'b0);
        for (int k = 0; k < 3; k++) begin
            next_tick();
            check($sformatf("t6_height_tick%0d", k), int'(bus_a.dinosaur_height), exp_dj[k]);
            if (k == 0) press(1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
